fp_result_retire: RTL and testbench

Retirement stage placed directly after the FP adder's final result-assembly stage. Captures each assembled 32-bit result with its four exception flags through a valid/ready handshake and buffers it in a small FIFO so the datapath can keep issuing while the consumer stalls. Accumulates IEEE-754 sticky exception flags. Raises a held trap request when an enabled exception retires.

---
 rtl/fp_result_retire_pkg.sv | 22 ++
 rtl/fp_retire_fifo.sv | 70 +++++++
 rtl/fp_result_retire.sv | 99 +++++++++
 tb/tb_fp_result_retire.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_result_retire_pkg.sv
// fp_result_retire_pkg
// Shared constants for the FP retirement stage: the FP word width, the number
// of exception flags, and the bit position of each flag inside a flag vector.
// Also provides a small helper that tells whether a flag vector hits any
// enabled trap.
package fp_result_retire_pkg;

   localparam int WIDTH   = 32;
   localparam int NFLAGS  = 4;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   // A trap is requested when any raised flag also has its trap enabled.
   function automatic logic trap_hit(input logic [NFLAGS-1:0] flags,
                                     input logic [NFLAGS-1:0] enables);
      return |(flags & enables);
   endfunction

endpackage

// File: rtl/fp_retire_fifo.sv
// fp_retire_fifo
// Small circular-buffer FIFO with a valid/ready interface on both sides.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   write handshake, in_data is captured on accept
//   out_valid/out_ready read handshake, out_data is the head entry
// in_ready depends only on the registered count, so there is no
// combinational path from out_ready to in_ready. A full FIFO refuses a push
// even if it is popped in the same cycle, and an empty FIFO never bypasses
// the incoming word straight to the output.
module fp_retire_fifo #(
   parameter int DW    = 36,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [DW-1:0] mem [DEPTH];
   logic          push;
   logic          pop;

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
   // pointers wrap naturally when they overflow their width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset; an entry is only ever read
   // once the count says it has been written.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/fp_result_retire.sv
// fp_result_retire
// Retirement stage following the FP adder's result assembly. Buffers each
// result and its exception flags in a small FIFO, accumulates sticky IEEE-754
// exception flags, raises a held trap request for enabled exceptions, and
// counts the results leaving on the output.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/in_result/in_flags     upstream result handshake
//   out_valid/out_ready/out_result/out_flags downstream result handshake
//   flags_clr, sticky_flags        clear and view the accumulated flags
//   trap_en, trap, trap_cause, trap_ack      trap enable, request, cause, ack
//   retired_cnt                    16-bit wrapping count of retired results
module fp_result_retire #(
   parameter int WIDTH = fp_result_retire_pkg::WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [3:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   input  logic             flags_clr,
   output logic [3:0]       sticky_flags,
   input  logic [3:0]       trap_en,
   output logic             trap,
   output logic [3:0]       trap_cause,
   input  logic             trap_ack,
   output logic [15:0]      retired_cnt
);

   import fp_result_retire_pkg::*;

   localparam int DW = WIDTH + NFLAGS;

   logic          accept;
   logic          retire;
   logic          hit;
   logic [DW-1:0] head;

   fp_retire_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_result, in_flags}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head)
   );

   assign out_result = head[DW-1:NFLAGS];
   assign out_flags  = head[NFLAGS-1:0];
   assign accept     = in_valid & in_ready;
   assign retire     = out_valid & out_ready;
   assign hit        = accept & trap_hit(in_flags, trap_en);

   // Sticky flags: a clear wipes the old value, but flags arriving with an
   // accepted result in the same cycle are still recorded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sticky_flags <= '0;
      else
         sticky_flags <= (flags_clr ? 4'b0000 : sticky_flags) |
                         (accept ? in_flags : 4'b0000);
   end

   // Trap request: the first enabled exception latches its flags as the
   // cause and later hits are ignored until acknowledged. An acknowledge
   // that coincides with a new hit re-arms the trap with the new cause.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trap       <= 1'b0;
         trap_cause <= '0;
      end else if (hit && (!trap || trap_ack)) begin
         trap       <= 1'b1;
         trap_cause <= in_flags;
      end else if (trap && trap_ack) begin
         trap       <= 1'b0;
         trap_cause <= '0;
      end
   end

   // Count of results handed to the consumer; wraps at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         retired_cnt <= '0;
      else if (retire)
         retired_cnt <= retired_cnt + 16'd1;
   end

endmodule

// File: tb/tb_fp_result_retire.sv
// tb_fp_result_retire
// Self-checking bench for fp_result_retire: a hand-derived vector table for
// the directed scenarios, an asynchronous reset sequence, a long streaming
// run that wraps the retired counter, and a randomized run checked against a
// queue-based reference model.
module tb_fp_result_retire;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_result = '0;
   logic [3:0]  in_flags = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [3:0]  out_flags;
   logic        flags_clr = 1'b0;
   logic [3:0]  sticky_flags;
   logic [3:0]  trap_en = '0;
   logic        trap;
   logic [3:0]  trap_cause;
   logic        trap_ack = 1'b0;
   logic [15:0] retired_cnt;

   int checks = 0;
   int errors = 0;

   fp_result_retire #(.WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_flags     (in_flags),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_flags    (out_flags),
      .flags_clr    (flags_clr),
      .sticky_flags (sticky_flags),
      .trap_en      (trap_en),
      .trap         (trap),
      .trap_cause   (trap_cause),
      .trap_ack     (trap_ack),
      .retired_cnt  (retired_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] res;
      logic [3:0]  fl;
      logic        ordy;
      logic        clr;
      logic [3:0]  ten;
      logic        ack;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_res;
      logic [3:0]  e_ofl;
      logic [3:0]  e_stk;
      logic        e_trap;
      logic [3:0]  e_cause;
      logic [15:0] e_ret;
   } vec_t;

   vec_t vecs[14];

   // Reference model state
   logic [35:0] mq[$];
   logic [3:0]  m_sticky;
   logic        m_trap;
   logic [3:0]  m_cause;
   logic [15:0] m_ret;

   function automatic vec_t mk(logic iv, logic [31:0] res, logic [3:0] fl,
                               logic ordy, logic clr, logic [3:0] ten, logic ack,
                               logic e_ov, logic e_ir, logic [31:0] e_res,
                               logic [3:0] e_ofl, logic [3:0] e_stk,
                               logic e_trap, logic [3:0] e_cause,
                               logic [15:0] e_ret);
      vec_t v;
      v.iv = iv; v.res = res; v.fl = fl; v.ordy = ordy; v.clr = clr;
      v.ten = ten; v.ack = ack; v.e_ov = e_ov; v.e_ir = e_ir;
      v.e_res = e_res; v.e_ofl = e_ofl; v.e_stk = e_stk;
      v.e_trap = e_trap; v.e_cause = e_cause; v.e_ret = e_ret;
      return v;
   endfunction

   task automatic applyStimulus(input logic iv, input logic [31:0] res,
                                input logic [3:0] fl, input logic ordy,
                                input logic clr, input logic [3:0] ten,
                                input logic ack);
      in_valid  = iv;
      in_result = res;
      in_flags  = fl;
      out_ready = ordy;
      flags_clr = clr;
      trap_en   = ten;
      trap_ack  = ack;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Advance the reference model by one clock edge using the inputs the
   // bench is currently driving.
   task automatic modelStep();
      bit acc, ret, hit;
      acc = in_valid && (mq.size() < DEPTH);
      ret = out_ready && (mq.size() > 0);
      hit = acc && ((in_flags & trap_en) != 4'b0000);
      if (ret) void'(mq.pop_front());
      if (acc) mq.push_back({in_result, in_flags});
      m_sticky = (flags_clr ? 4'b0000 : m_sticky) | (acc ? in_flags : 4'b0000);
      if (m_trap && trap_ack && !hit) begin
         m_trap  = 1'b0;
         m_cause = 4'b0000;
      end else if (hit && (!m_trap || trap_ack)) begin
         m_trap  = 1'b1;
         m_cause = in_flags;
      end
      if (ret) m_ret = m_ret + 16'd1;
   endtask

   initial begin
      int bubbles, order_err, not_ready;

      // Directed vectors, each row describes one clock edge starting from reset
      vecs[0]  = mk(1, 32'h3F800000, 4'b0000, 0, 0, 4'b0000, 0, 1, 1, 32'h3F800000, 4'b0000, 4'b0000, 0, 4'b0000, 16'd0);
      vecs[1]  = mk(0, 32'h0,        4'b0000, 1, 0, 4'b0000, 0, 0, 1, 32'h0,        4'b0000, 4'b0000, 0, 4'b0000, 16'd1);
      vecs[2]  = mk(1, 32'hA0000001, 4'b0000, 0, 0, 4'b0000, 0, 1, 1, 32'hA0000001, 4'b0000, 4'b0000, 0, 4'b0000, 16'd1);
      vecs[3]  = mk(1, 32'hA0000002, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 32'hA0000001, 4'b0000, 4'b0000, 0, 4'b0000, 16'd1);
      vecs[4]  = mk(1, 32'hA0000003, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 32'hA0000001, 4'b0000, 4'b0000, 0, 4'b0000, 16'd1);
      vecs[5]  = mk(1, 32'hA0000003, 4'b0000, 1, 0, 4'b0000, 0, 1, 1, 32'hA0000002, 4'b0000, 4'b0000, 0, 4'b0000, 16'd2);
      vecs[6]  = mk(0, 32'h0,        4'b0000, 1, 0, 4'b0000, 0, 0, 1, 32'h0,        4'b0000, 4'b0000, 0, 4'b0000, 16'd3);
      vecs[7]  = mk(1, 32'h7F800000, 4'b0101, 0, 0, 4'b0100, 0, 1, 1, 32'h7F800000, 4'b0101, 4'b0101, 1, 4'b0101, 16'd3);
      vecs[8]  = mk(1, 32'h11111111, 4'b1000, 1, 0, 4'b1111, 0, 1, 1, 32'h11111111, 4'b1000, 4'b1101, 1, 4'b0101, 16'd4);
      vecs[9]  = mk(0, 32'h0,        4'b0000, 1, 0, 4'b0000, 1, 0, 1, 32'h0,        4'b0000, 4'b1101, 0, 4'b0000, 16'd5);
      vecs[10] = mk(1, 32'h22222222, 4'b0010, 0, 1, 4'b0000, 0, 1, 1, 32'h22222222, 4'b0010, 4'b0010, 0, 4'b0000, 16'd5);
      vecs[11] = mk(1, 32'h33333333, 4'b1000, 1, 0, 4'b1000, 0, 1, 1, 32'h33333333, 4'b1000, 4'b1010, 1, 4'b1000, 16'd6);
      vecs[12] = mk(1, 32'h44444444, 4'b0001, 1, 0, 4'b0001, 1, 1, 1, 32'h44444444, 4'b0001, 4'b1011, 1, 4'b0001, 16'd7);
      vecs[13] = mk(0, 32'h0,        4'b0000, 1, 1, 4'b0000, 1, 0, 1, 32'h0,        4'b0000, 4'b0000, 0, 4'b0000, 16'd8);

      $display("[TB] directed vectors");
      doReset();
      checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst.sticky", 32'(sticky_flags), 32'd0);
      checkOutput("rst.trap", 32'(trap), 32'd0);
      checkOutput("rst.cause", 32'(trap_cause), 32'd0);
      checkOutput("rst.retired", 32'(retired_cnt), 32'd0);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].res, vecs[i].fl, vecs[i].ordy,
                       vecs[i].clr, vecs[i].ten, vecs[i].ack);
         @(negedge clk);
         checkOutput($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         checkOutput($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
         if (vecs[i].e_ov) begin
            checkOutput($sformatf("v%0d.out_result", i), out_result, vecs[i].e_res);
            checkOutput($sformatf("v%0d.out_flags", i), 32'(out_flags), 32'(vecs[i].e_ofl));
         end
         checkOutput($sformatf("v%0d.sticky", i), 32'(sticky_flags), 32'(vecs[i].e_stk));
         checkOutput($sformatf("v%0d.trap", i), 32'(trap), 32'(vecs[i].e_trap));
         checkOutput($sformatf("v%0d.cause", i), 32'(trap_cause), 32'(vecs[i].e_cause));
         checkOutput($sformatf("v%0d.retired", i), 32'(retired_cnt), 32'(vecs[i].e_ret));
      end

      // Asynchronous reset with two entries buffered and a trap pending
      $display("[TB] async reset");
      doReset();
      applyStimulus(1, 32'h55555555, 4'b0100, 0, 0, 4'b0100, 0);
      @(negedge clk);
      applyStimulus(1, 32'h66666666, 4'b0000, 0, 0, 4'b0000, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("ar.pre_in_ready", 32'(in_ready), 32'd0);
      checkOutput("ar.pre_trap", 32'(trap), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("ar.out_valid", 32'(out_valid), 32'd0);
      checkOutput("ar.in_ready", 32'(in_ready), 32'd1);
      checkOutput("ar.trap", 32'(trap), 32'd0);
      checkOutput("ar.cause", 32'(trap_cause), 32'd0);
      checkOutput("ar.sticky", 32'(sticky_flags), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Streaming run long enough to wrap the retired counter
      $display("[TB] streaming run");
      doReset();
      bubbles = 0;
      order_err = 0;
      not_ready = 0;
      for (int i = 0; i < 70000; i++) begin
         applyStimulus(1, 32'(i), 4'b0000, 1, 0, 4'b0000, 0);
         @(negedge clk);
         if (out_valid !== 1'b1) bubbles++;
         if (out_result !== 32'(i)) order_err++;
         if (in_ready !== 1'b1) not_ready++;
      end
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      checkOutput("st.bubbles", 32'(bubbles), 32'd0);
      checkOutput("st.order", 32'(order_err), 32'd0);
      checkOutput("st.in_ready", 32'(not_ready), 32'd0);
      checkOutput("st.retired", 32'(retired_cnt), 32'd4464);
      checkOutput("st.drained", 32'(out_valid), 32'd0);

      // Randomized run against the reference model
      $display("[TB] random run");
      doReset();
      mq.delete();
      m_sticky = '0;
      m_trap   = 1'b0;
      m_cause  = '0;
      m_ret    = '0;
      for (int c = 0; c < 3000; c++) begin
         checkOutput($sformatf("r%0d.out_valid", c), 32'(out_valid), 32'(mq.size() != 0));
         checkOutput($sformatf("r%0d.in_ready", c), 32'(in_ready), 32'(mq.size() < DEPTH));
         if (mq.size() != 0) begin
            checkOutput($sformatf("r%0d.out_result", c), out_result, mq[0][35:4]);
            checkOutput($sformatf("r%0d.out_flags", c), 32'(out_flags), 32'(mq[0][3:0]));
         end
         checkOutput($sformatf("r%0d.sticky", c), 32'(sticky_flags), 32'(m_sticky));
         checkOutput($sformatf("r%0d.trap", c), 32'(trap), 32'(m_trap));
         checkOutput($sformatf("r%0d.cause", c), 32'(trap_cause), 32'(m_cause));
         checkOutput($sformatf("r%0d.retired", c), 32'(retired_cnt), 32'(m_ret));
         applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
                       1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 7) == 0),
                       4'($urandom) & 4'($urandom),
                       1'($urandom_range(0, 3) == 0));
         @(posedge clk);
         modelStep();
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
